run_control: RTL and testbench
==============================

# run_control

Parametrised run-control and debug unit for the single-cycle processor system. It sits between the board-level controls and the processor core. It gates the program-counter enable and data-memory write enable, which gives run, halt and single-step execution with programmable instruction-address breakpoints. It also counts retired instructions and provides an auto-incrementing, registered data-memory inspection port for board displays.

## Interface
- IADDR_W, 5: instruction address width
- DADDR_W, 4: data memory address width
- DATA_W, 8: data memory word width
- NUM_BP, 2: number of breakpoint channels (≥1)
- CNT_W, 16: retired-instruction counter width
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run_req  in  1  start free-running execution (pulse)
- step_req  in  1  execute exactly one instruction (pulse)
- halt_req  in  1  stop execution (pulse)
- core_halt  in  1  core has decoded a halt instruction at inst_addr
- inst_addr  in  IADDR_W  current instruction address from the program counter
- core_mem_write  in  1  core data-memory write request
- bp_set  in  1  load breakpoint channel bp_idx
- bp_idx  in  $clog2(NUM_BP) (min 1)  channel to load
- bp_addr  in  IADDR_W  breakpoint address
- bp_valid  in  1  enable (1) or disable (0) the loaded channel
- pc_enable  out  1  program-counter advance enable
- mem_write  out  1  gated data-memory write enable, equal to core_mem_write & pc_enable
- state  out  2  00 HALTED, 01 RUN, 10 STEP
- bp_hit  out  1  sticky flag: the last stop was caused by a breakpoint
- bp_hit_idx  out  $clog2(NUM_BP) (min 1)  lowest matching channel of the last breakpoint stop
- retired  out  CNT_W  count of cycles with pc_enable=1
- insp_next  in  1  advance the inspection address
- insp_addr  out  DADDR_W  inspection read address to data memory
- insp_data  in  DATA_W  data memory read data at insp_addr
- insp_data_q  out  DATA_W  registered inspection data

## Operation
- FSM states:
  - HALTED: pc_enable=0.
  - RUN: pc_enable=1 unless a stop condition holds.
  - STEP: pc_enable=1 for one cycle unless core_halt=1.
- HALTED transitions:
  - halt_req has top priority and keeps the FSM in HALTED.
  - Otherwise step_req goes to STEP.
  - Otherwise run_req goes to RUN.
- RUN stop conditions, evaluated combinationally in the same cycle:
  - halt_req;
  - core_halt;
  - breakpoint match: an enabled channel has bp_addr == inst_addr, and the resume-skip flag is clear.
- On a RUN stop condition: pc_enable=0 in that cycle, and the next state is HALTED.
- A breakpoint stop sets bp_hit=1 and latches bp_hit_idx.
- Resume-skip flag:
  - Set on every HALTED→RUN or HALTED→STEP transition.
  - Cleared after the first cycle spent in RUN or STEP.
  - This lets execution resume from a breakpointed address.
- STEP always returns to HALTED after one cycle. If core_halt=1 in that cycle, pc_enable=0.
- Leaving HALTED clears bp_hit.
- run_req or step_req while in RUN or STEP is ignored.
- Breakpoint programming:
  - A bp_set pulse writes addr and valid into channel bp_idx on the next edge. It is legal in any state.
  - An out-of-range bp_idx is ignored.
  - When several channels match, bp_hit_idx reports the lowest index.
- retired increments on each cycle with pc_enable=1 and saturates at 2^CNT_W−1.
- Inspection port:
  - insp_next increments insp_addr, wrapping from 2^DADDR_W−1 to 0.
  - insp_data_q <= insp_data every cycle.

## Timing
- Reset values:
  - state=HALTED, pc_enable=0, mem_write=0, bp_hit=0, bp_hit_idx=0, retired=0, insp_addr=0, insp_data_q=0.
  - All channels are invalid, with addr=0.
- Reset asserted mid-RUN: pc_enable is forced to 0 in that same cycle, and every register takes its reset value at the edge.
- pc_enable and mem_write are combinational from state, the request inputs, inst_addr and the breakpoint registers. There is no added latency: a stop suppresses the current instruction.
- A request pulse sampled at edge N changes state after edge N. The instruction is enabled in cycle N+1.
- insp_data_q has a latency of 1 cycle from insp_addr.
- A new breakpoint becomes effective in the cycle after bp_set.

## Configuration
- RUN_CONTROL_BP_EN:
  - Defined: breakpoint channels, bp_hit and bp_hit_idx are implemented as described.
  - Undefined: no breakpoint storage exists, bp_set, bp_idx, bp_addr and bp_valid are ignored, bp_hit and bp_hit_idx are tied to 0, and RUN stops only on halt_req or core_halt.

## Test plan
- Reset, then 3 idle cycles → state=00, pc_enable=0, retired=0, insp_addr=0.
- run_req pulse, core_halt asserted when inst_addr=7 → pc_enable=1 for 7 cycles, then 0; state returns to 00; retired=7.
- Channel 1 loaded with addr 4, then run_req → stop with inst_addr=4, bp_hit=1, bp_hit_idx=1. A second run_req → the instruction at 4 executes (pc_enable=1) and execution continues.
- Three step_req pulses spaced 2 cycles apart → exactly 3 single-cycle pc_enable pulses; retired=3. core_mem_write=1 while halted → mem_write=0.
- halt_req and run_req in the same cycle while HALTED → state stays 00. reset mid-RUN → pc_enable=0 in that cycle, then all reset values.
- 17 insp_next pulses with DADDR_W=4 → insp_addr=1 (wrapped through 0). insp_data_q equals the memory word from the previous cycle. retired saturates at 0xFFFF with CNT_W=16.

Source files
------------

// File: rtl/run_control.sv
// run_control: run/halt/single-step gating of the core, instruction breakpoints,
// retired-instruction counter and registered data-memory inspection port.
// Breakpoint channels exist only when RUN_CONTROL_BP_EN is defined.
module run_control #(
    parameter int unsigned IADDR_W = 5,
    parameter int unsigned DADDR_W = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_BP  = 2,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run_req,
    input  logic               step_req,
    input  logic               halt_req,
    input  logic               core_halt,
    input  logic [IADDR_W-1:0] inst_addr,
    input  logic               core_mem_write,
    input  logic               bp_set,
    input  logic [IDX_W-1:0]   bp_idx,
    input  logic [IADDR_W-1:0] bp_addr,
    input  logic               bp_valid,
    output logic               pc_enable,
    output logic               mem_write,
    output logic [1:0]         state,
    output logic               bp_hit,
    output logic [IDX_W-1:0]   bp_hit_idx,
    output logic [CNT_W-1:0]   retired,
    input  logic               insp_next,
    output logic [DADDR_W-1:0] insp_addr,
    input  logic [DATA_W-1:0]  insp_data,
    output logic [DATA_W-1:0]  insp_data_q
);

    typedef enum logic [1:0] {
        ST_HALTED = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   skip_q;
    logic   bp_match;
    logic   bp_stop;
    logic   leave_halted;

`ifdef RUN_CONTROL_BP_EN
    logic [IADDR_W-1:0] bp_addr_q [NUM_BP];
    logic [NUM_BP-1:0]  bp_valid_q;
    logic [IDX_W-1:0]   match_idx;

    // Descending scan so the lowest matching channel wins
    always_comb begin
        bp_match  = 1'b0;
        match_idx = '0;
        for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
            if (bp_valid_q[i] && (bp_addr_q[i] == inst_addr)) begin
                bp_match  = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bp_valid_q <= '0;
            for (int i = 0; i < int'(NUM_BP); i++) begin
                bp_addr_q[i] <= '0;
            end
        end else if (bp_set && (32'(bp_idx) < NUM_BP)) begin
            bp_valid_q[bp_idx] <= bp_valid;
            bp_addr_q[bp_idx]  <= bp_addr;
        end
    end

    // Sticky breakpoint status, cleared when execution resumes
    always_ff @(posedge clk) begin
        if (reset) begin
            bp_hit     <= 1'b0;
            bp_hit_idx <= '0;
        end else if (bp_stop) begin
            bp_hit     <= 1'b1;
            bp_hit_idx <= match_idx;
        end else if (leave_halted) begin
            bp_hit     <= 1'b0;
        end
    end
`else
    logic unused_bp;

    assign unused_bp  = ^{bp_set, bp_idx, bp_addr, bp_valid};
    assign bp_match   = 1'b0;
    assign bp_hit     = 1'b0;
    assign bp_hit_idx = '0;
`endif

    // Skip flag lets a resume execute the instruction sitting on a breakpoint
    assign bp_stop      = (state_q == ST_RUN) && bp_match && !skip_q;
    assign leave_halted = (state_q == ST_HALTED) && (state_d != ST_HALTED);

    // Next state and same-cycle enable gating
    always_comb begin
        state_d   = state_q;
        pc_enable = 1'b0;
        unique case (state_q)
            ST_HALTED: begin
                if (halt_req) begin
                    state_d = ST_HALTED;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end else if (run_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req || core_halt || bp_stop) begin
                    state_d = ST_HALTED;
                end else begin
                    pc_enable = 1'b1;
                end
            end
            ST_STEP: begin
                state_d   = ST_HALTED;
                pc_enable = !core_halt;
            end
            default: state_d = ST_HALTED;
        endcase
        if (reset) begin
            pc_enable = 1'b0;
        end
    end

    assign mem_write = core_mem_write & pc_enable;
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HALTED;
            skip_q      <= 1'b0;
            retired     <= '0;
            insp_addr   <= '0;
            insp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_HALTED) begin
                if (leave_halted) begin
                    skip_q <= 1'b1;
                end
            end else begin
                skip_q <= 1'b0;
            end
            if (pc_enable && (retired != '1)) begin
                retired <= retired + CNT_W'(1);
            end
            if (insp_next) begin
                insp_addr <= insp_addr + DADDR_W'(1);
            end
            insp_data_q <= insp_data;
        end
    end

endmodule

// File: tb/tb_run_control.sv
// Scoreboard bench for run_control: a behavioural model queues per-cycle expectations,
// a negedge monitor compares them against the DUT; directed checks follow the test plan.
module tb_run_control;

    localparam int unsigned IADDR_W = 5;
    localparam int unsigned DADDR_W = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned NUM_BP  = 2;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned IDX_W   = 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef RUN_CONTROL_BP_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset, run_req, step_req, halt_req, core_halt;
    logic [IADDR_W-1:0] inst_addr;
    logic               core_mem_write, bp_set, bp_valid, insp_next;
    logic [IDX_W-1:0]   bp_idx;
    logic [IADDR_W-1:0] bp_addr;
    logic               pc_enable, mem_write, bp_hit;
    logic [1:0]         state;
    logic [IDX_W-1:0]   bp_hit_idx;
    logic [CNT_W-1:0]   retired;
    logic [DADDR_W-1:0] insp_addr;
    logic [DATA_W-1:0]  insp_data, insp_data_q;
    logic [DATA_W-1:0]  mem [1 << DADDR_W];

    assign insp_data = mem[insp_addr];

    run_control dut (
        .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req),
        .halt_req(halt_req), .core_halt(core_halt), .inst_addr(inst_addr),
        .core_mem_write(core_mem_write), .bp_set(bp_set), .bp_idx(bp_idx),
        .bp_addr(bp_addr), .bp_valid(bp_valid), .pc_enable(pc_enable),
        .mem_write(mem_write), .state(state), .bp_hit(bp_hit),
        .bp_hit_idx(bp_hit_idx), .retired(retired), .insp_next(insp_next),
        .insp_addr(insp_addr), .insp_data(insp_data), .insp_data_q(insp_data_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]         st;
        logic               en;
        logic               mw;
        logic               hit;
        logic [IDX_W-1:0]   hidx;
        logic [CNT_W-1:0]   ret;
        logic [DADDR_W-1:0] ia;
        logic [DATA_W-1:0]  dq;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 halted, 1 run, 2 step
    int               m_state, m_hidx, m_ret, m_ia, pc, halt_at;
    bit               m_skip, m_hit, follow_pc;
    bit               m_bpv [NUM_BP];
    int               m_bpa [NUM_BP];
    logic [DATA_W-1:0] m_dq;

    function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_state = 0; m_skip = 0; m_hit = 0; m_hidx = 0; m_ret = 0; m_ia = 0;
        m_dq = '0; pc = 0;
        for (int i = 0; i < int'(NUM_BP); i++) begin
            m_bpv[i] = 0;
            m_bpa[i] = 0;
        end
    endfunction

    // Predict this cycle, queue it, then advance the model across the edge
    task automatic tick();
        exp_t e;
        bit match, stop_bp, en;
        int hidx, ns;
        logic [DATA_W-1:0] dq_next;
        match = 0; hidx = 0;
        for (int i = 0; i < int'(NUM_BP); i++) begin
            if (BP_EN && m_bpv[i] && m_bpa[i] == int'(inst_addr) && !match) begin
                match = 1;
                hidx  = i;
            end
        end
        stop_bp = (m_state == 1) && match && !m_skip;
        case (m_state)
            1:       en = !(halt_req || core_halt || stop_bp);
            2:       en = !core_halt;
            default: en = 0;
        endcase
        if (reset) en = 0;
        e.st = 2'(m_state); e.en = en; e.mw = en && core_mem_write;
        e.hit = m_hit; e.hidx = IDX_W'(m_hidx); e.ret = CNT_W'(m_ret);
        e.ia = DADDR_W'(m_ia); e.dq = m_dq;
        sb.push_back(e);
        ns = m_state;
        if (m_state == 0) begin
            if (!halt_req && step_req) ns = 2;
            else if (!halt_req && run_req) ns = 1;
        end else if (m_state == 2 || !en) begin
            ns = 0;
        end
        dq_next = mem[m_ia];
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (m_state == 0 && ns != 0) begin
                m_skip = 1;
                m_hit  = 0;
            end else if (m_state != 0) begin
                m_skip = 0;
            end
            if (stop_bp) begin
                m_hit  = 1;
                m_hidx = hidx;
            end
            if (bp_set && int'(bp_idx) < int'(NUM_BP)) begin
                m_bpv[bp_idx] = bp_valid;
                m_bpa[bp_idx] = int'(bp_addr);
            end
            if (en && m_ret < CNT_MAX) m_ret++;
            if (insp_next) m_ia = (m_ia + 1) % (1 << DADDR_W);
            m_dq = dq_next;
            if (en) pc = (pc + 1) % (1 << IADDR_W);
            m_state = ns;
        end
        #1;
        run_req = 0; step_req = 0; halt_req = 0; bp_set = 0; insp_next = 0;
        if (follow_pc) begin
            inst_addr = IADDR_W'(pc);
            core_halt = (halt_at >= 0) && (pc == halt_at);
        end
    endtask

    task automatic run_until_halt(input int max_cycles);
        for (int i = 0; i < max_cycles && m_state != 0; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    // Monitor: one queued expectation per cycle, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp("state", 32'(state), 32'(e.st));
            cmp("pc_enable", 32'(pc_enable), 32'(e.en));
            cmp("mem_write", 32'(mem_write), 32'(e.mw));
            cmp("bp_hit", 32'(bp_hit), 32'(e.hit));
            cmp("bp_hit_idx", 32'(bp_hit_idx), 32'(e.hidx));
            cmp("retired", 32'(retired), 32'(e.ret));
            cmp("insp_addr", 32'(insp_addr), 32'(e.ia));
            cmp("insp_data_q", 32'(insp_data_q), 32'(e.dq));
        end
    end

    initial begin
        reset = 1; run_req = 0; step_req = 0; halt_req = 0; core_halt = 0;
        inst_addr = '0; core_mem_write = 0; bp_set = 0; bp_idx = '0;
        bp_addr = '0; bp_valid = 0; insp_next = 0;
        follow_pc = 1; halt_at = -1;
        for (int i = 0; i < (1 << DADDR_W); i++) mem[i] = DATA_W'($urandom);
        model_reset();
        @(posedge clk);
        #1;

        // Reset then idle
        do_reset();
        repeat (3) tick();
        #1;
        cmp("idle_state", 32'(state), 0);
        cmp("idle_pc_enable", 32'(pc_enable), 0);
        cmp("idle_retired", 32'(retired), 0);
        cmp("idle_insp_addr", 32'(insp_addr), 0);

        // Free run until core_halt at address 7
        halt_at = 7;
        run_req = 1;
        tick();
        run_until_halt(30);
        #1;
        cmp("halt7_state", 32'(state), 0);
        cmp("halt7_retired", 32'(retired), 7);

        // Breakpoint on channel 1 at address 4, then resume past it
        halt_at = 12;
        do_reset();
        bp_set = 1; bp_idx = 1'b1; bp_addr = IADDR_W'(4); bp_valid = 1;
        tick();
        run_req = 1;
        tick();
        run_until_halt(40);
        #1;
`ifdef RUN_CONTROL_BP_EN
        cmp("bp_stop_addr", 32'(inst_addr), 4);
        cmp("bp_stop_hit", 32'(bp_hit), 1);
        cmp("bp_stop_idx", 32'(bp_hit_idx), 1);
        cmp("bp_stop_retired", 32'(retired), 4);
        run_req = 1;
        tick();
        #1;
        cmp("bp_resume_en", 32'(pc_enable), 1);
        run_until_halt(40);
        #1;
`endif
        cmp("bp_end_state", 32'(state), 0);
        cmp("bp_end_retired", 32'(retired), 12);
        cmp("bp_end_hit", 32'(bp_hit), 0);

        // Three single steps, then write gating while halted
        halt_at = -1;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step_req = 1;
            tick();
            tick();
            tick();
        end
        #1;
        cmp("step_retired", 32'(retired), 3);
        core_mem_write = 1;
        #1;
        cmp("halted_mem_write", 32'(mem_write), 0);
        tick();
        tick();
        core_mem_write = 0;

        // Simultaneous halt and run while halted
        halt_req = 1; run_req = 1;
        tick();
        tick();
        #1;
        cmp("halt_run_state", 32'(state), 0);

        // Reset in the middle of a run
        run_req = 1;
        tick();
        tick();
        tick();
        reset = 1;
        #1;
        cmp("midrun_reset_en", 32'(pc_enable), 0);
        tick();
        reset = 0;
        #1;
        cmp("post_reset_state", 32'(state), 0);
        cmp("post_reset_retired", 32'(retired), 0);
        cmp("post_reset_en", 32'(pc_enable), 0);

        // Inspection address wrap and data latency
        repeat (17) begin
            insp_next = 1;
            tick();
        end
        #1;
        cmp("insp_wrap_addr", 32'(insp_addr), 1);
        cmp("insp_data_lat", 32'(insp_data_q), 32'(mem[0]));

        // Retired counter saturation
        do_reset();
        run_req = 1;
        tick();
        repeat (CNT_MAX + 5) tick();
        #1;
        cmp("retired_sat", 32'(retired), 32'(CNT_MAX));
        halt_req = 1;
        tick();

        // Randomised traffic against the model
        follow_pc = 0;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            reset          = ($urandom_range(0, 199) == 0);
            run_req        = ($urandom_range(0, 9) == 0);
            step_req       = ($urandom_range(0, 9) == 0);
            halt_req       = ($urandom_range(0, 14) == 0);
            core_halt      = ($urandom_range(0, 11) == 0);
            inst_addr      = IADDR_W'($urandom_range(0, 7));
            core_mem_write = 1'($urandom_range(0, 1));
            bp_set         = ($urandom_range(0, 7) == 0);
            bp_idx         = IDX_W'($urandom_range(0, 1));
            bp_addr        = IADDR_W'($urandom_range(0, 7));
            bp_valid       = ($urandom_range(0, 3) != 0);
            insp_next      = 1'($urandom_range(0, 1));
            mem[$urandom_range(0, (1 << DADDR_W) - 1)] = DATA_W'($urandom);
            tick();
        end
        reset = 0;

        @(negedge clk);
        #1;
        cmp("scoreboard_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
